// File: rtl/ysyx_25010008_axi_pkg.sv
// AXI4-Lite response codes and responder FSM encodings.
// Shared by the LSU initiator and the SRAM responder.
package ysyx_25010008_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/ysyx_25010008_delay_cnt.sv
// Loadable 8-bit down-counter; done while the count sits at zero.
// Load wins over decrement.
module ysyx_25010008_delay_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_val,
    input  logic       i_en,
    output logic       o_done
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/ysyx_25010008_axil_sram.sv
// AXI4-Lite SRAM responder with fixed read/write response latency.
// Out-of-window accesses answer DECERR and never touch memory.
module ysyx_25010008_axil_sram
    import ysyx_25010008_axi_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LATENCY = 1,
    parameter int          WR_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [31:0] WIN    = 32'd4 << DEPTH_LOG2;
    localparam logic [7:0]  RD_LAT = 8'(RD_LATENCY);
    localparam logic [7:0]  WR_LAT = 8'(WR_LATENCY);

    reg [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    rd_state_e r_rstate, w_rnext;
    wr_state_e r_wstate, w_wnext;
    logic      r_live;

    logic [31:0] r_araddr, r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_held, r_w_held;
    logic [1:0]  r_bresp;

    logic [31:0]           w_roff, w_woff;
    logic                  w_rin, w_win;
    logic [DEPTH_LOG2-1:0] w_ridx, w_widx;
    logic                  w_ar_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_both, w_rdone, w_wdone;
    logic                  w_rsample, w_wlast, w_commit;

    assign w_roff = r_araddr - BASE;
    assign w_rin  = w_roff < WIN;
    assign w_ridx = w_roff[DEPTH_LOG2+1:2];
    assign w_woff = r_awaddr - BASE;
    assign w_win  = w_woff < WIN;
    assign w_widx = w_woff[DEPTH_LOG2+1:2];

    assign arready = r_live && (r_rstate == R_IDLE);
    assign rvalid  = (r_rstate == R_RESP);
    assign awready = r_live && (r_wstate == W_IDLE) && !r_aw_held;
    assign wready  = r_live && (r_wstate == W_IDLE) && !r_w_held;
    assign bvalid  = (r_wstate == W_RESP);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign bresp   = r_bresp;

    assign w_ar_hs = arvalid && arready;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_b_hs  = bvalid && bready;
    // Either channel may arrive first; the later one starts the timer.
    assign w_both  = (r_wstate == W_IDLE)
                   && (r_aw_held || w_aw_hs)
                   && (r_w_held || w_w_hs);

    assign w_rsample = (r_rstate == R_WAIT) && w_rdone;
    assign w_wlast   = (r_wstate == W_WAIT) && w_wdone;
    assign w_commit  = w_wlast && w_win;

    ysyx_25010008_delay_cnt u_rcnt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_ar_hs),
        .i_val   (RD_LAT),
        .i_en    (r_rstate == R_WAIT),
        .o_done  (w_rdone)
    );

    ysyx_25010008_delay_cnt u_wcnt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_both),
        .i_val   (WR_LAT),
        .i_en    (r_wstate == W_WAIT),
        .o_done  (w_wdone)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_rstate <= w_rnext;
            r_wstate <= w_wnext;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_WAIT;
            R_WAIT:  if (w_rdone) w_rnext = R_RESP;
            R_RESP:  if (rready)  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_both)  w_wnext = W_WAIT;
            W_WAIT:  if (w_wdone) w_wnext = W_RESP;
            W_RESP:  if (bready)  w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_araddr <= 32'd0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_ar_hs) r_araddr <= araddr;
            if (w_rsample) begin
                r_rdata <= w_rin ? r_mem[w_ridx] : 32'd0;
                r_rresp <= w_rin ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_awaddr  <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_awaddr  <= awaddr;
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
                r_w_held <= 1'b1;
            end
            if (w_wlast) r_bresp <= w_win ? RESP_OKAY : RESP_DECERR;
            if (w_b_hs) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Same-edge read sample sees the pre-write word.
    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_axil_sram.sv
// Bench for the AXI4-Lite SRAM responder: three latency configurations,
// table-driven transactions plus collision and mid-write reset sequences.
module tb_ysyx_25010008_axil_sram;
    import ysyx_25010008_axi_pkg::*;

    localparam int RL [3] = '{1, 0, 5};
    localparam int WL [3] = '{1, 0, 2};

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [31:0] araddr [3];
    logic [2:0]  arvalid, arready;
    logic [31:0] rdata [3];
    logic [1:0]  rresp [3];
    logic [2:0]  rvalid, rready;
    logic [31:0] awaddr [3];
    logic [2:0]  awvalid, awready;
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [2:0]  wvalid, wready;
    logic [1:0]  bresp [3];
    logic [2:0]  bvalid, bready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  r;
        int          order;
        int          gap;
    } vec_t;

    vec_t vt [21];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_25010008_axil_sram #(
            .BASE       (32'h8000_0000),
            .DEPTH_LOG2 (12),
            .RD_LATENCY (RL[g]),
            .WR_LATENCY (WL[g])
        ) dut (
            .clock   (clock),
            .reset   (reset),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .awaddr  (awaddr[g]),
            .awvalid (awvalid[g]),
            .awready (awready[g]),
            .wdata   (wdata[g]),
            .wstrb   (wstrb[g]),
            .wvalid  (wvalid[g]),
            .wready  (wready[g]),
            .bresp   (bresp[g]),
            .bvalid  (bvalid[g]),
            .bready  (bready[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // hold = cycles rready stays low once rvalid is seen
    task automatic do_read(input int k, input logic [31:0] a,
                           input logic [31:0] ed, input logic [1:0] er,
                           input int hold);
        int n;
        exp_t e;
        rq.push_back('{ed, er});
        araddr[k]  = a;
        arvalid[k] = 1'b1;
        n = 0;
        while (!arready[k] && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("ar_accept", 64'(arready[k]), 64'd1);
        @(negedge clock);
        arvalid[k] = 1'b0;
        chk("ar_busy", 64'(arready[k]), 64'd0);
        n = 0;
        while (!rvalid[k] && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("r_latency", 64'(n), 64'(1 + RL[k]));
        e = rq.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("r_hold", 64'({rvalid[k], arready[k], rdata[k], rresp[k]}),
                64'({1'b1, 1'b0, e.data, e.resp}));
        end
        chk("rdata", 64'(rdata[k]), 64'(e.data));
        chk("rresp", 64'(rresp[k]), 64'(e.resp));
        rready[k] = 1'b1;
        @(negedge clock);
        rready[k] = 1'b0;
        chk("r_done", 64'({rvalid[k], arready[k]}), 64'd1);
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first
    task automatic do_write(input int k, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input int order,
                            input int gap);
        int n;
        exp_t e;
        bq.push_back('{32'd0, er});
        awaddr[k] = a;
        wdata[k]  = d;
        wstrb[k]  = s;
        chk("aw_w_ready", 64'({awready[k], wready[k]}), 64'd3);
        if (order == 0) begin
            awvalid[k] = 1'b1;
            wvalid[k]  = 1'b1;
            @(negedge clock);
            awvalid[k] = 1'b0;
            wvalid[k]  = 1'b0;
        end else begin
            if (order == 1) wvalid[k] = 1'b1;
            else awvalid[k] = 1'b1;
            @(negedge clock);
            awvalid[k] = 1'b0;
            wvalid[k]  = 1'b0;
            chk("held_ready", 64'({awready[k], wready[k]}),
                (order == 1) ? 64'd2 : 64'd1);
            repeat (gap - 1) @(negedge clock);
            chk("b_early", 64'(bvalid[k]), 64'd0);
            if (order == 1) awvalid[k] = 1'b1;
            else wvalid[k] = 1'b1;
            @(negedge clock);
            awvalid[k] = 1'b0;
            wvalid[k]  = 1'b0;
        end
        n = 0;
        while (!bvalid[k] && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("b_latency", 64'(n), 64'(1 + WL[k]));
        e = bq.pop_front();
        chk("bresp", 64'(bresp[k]), 64'(e.resp));
        bready[k] = 1'b1;
        @(negedge clock);
        bready[k] = 1'b0;
        chk("b_done", 64'({bvalid[k], awready[k], wready[k]}), 64'd3);
    endtask

    initial begin
        int n;
        vt[0]  = '{0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   0, 0};
        vt[1]  = '{0, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, RESP_OKAY,   0, 0};
        vt[2]  = '{0, 1'b1, 32'h8000_0012, 32'h1111_1111, 4'hF, RESP_OKAY,   0, 0};
        vt[3]  = '{0, 1'b1, 32'h8000_0012, 32'h00AB_0000, 4'h4, RESP_OKAY,   0, 0};
        vt[4]  = '{0, 1'b0, 32'h8000_0010, 32'h11AB_1111, 4'h0, RESP_OKAY,   0, 0};
        vt[5]  = '{0, 1'b1, 32'h8000_0014, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   1, 3};
        vt[6]  = '{0, 1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   0, 0};
        vt[7]  = '{0, 1'b0, 32'h8000_0014, 32'hCAFE_F00D, 4'h0, RESP_OKAY,   0, 0};
        vt[8]  = '{0, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, RESP_OKAY,   0, 0};
        vt[9]  = '{0, 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, RESP_DECERR, 0, 0};
        vt[10] = '{0, 1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 4'h0, RESP_OKAY,   0, 0};
        vt[11] = '{0, 1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, RESP_DECERR, 0, 0};
        vt[12] = '{0, 1'b1, 32'h8000_3FFC, 32'h7654_3210, 4'hF, RESP_OKAY,   2, 3};
        vt[13] = '{0, 1'b0, 32'h8000_3FFF, 32'h7654_3210, 4'h0, RESP_OKAY,   0, 0};
        vt[14] = '{0, 1'b0, 32'h8000_4000, 32'h0000_0000, 4'h0, RESP_DECERR, 0, 0};
        vt[15] = '{1, 1'b1, 32'h8000_0100, 32'h5555_AAAA, 4'hF, RESP_OKAY,   0, 0};
        vt[16] = '{1, 1'b0, 32'h8000_0100, 32'h5555_AAAA, 4'h0, RESP_OKAY,   0, 4};
        vt[17] = '{2, 1'b1, 32'h8000_0104, 32'h0F0F_0F0F, 4'hF, RESP_OKAY,   1, 3};
        vt[18] = '{2, 1'b1, 32'h8000_0104, 32'h0000_0080, 4'h1, RESP_OKAY,   2, 1};
        vt[19] = '{2, 1'b0, 32'h8000_0104, 32'h0F0F_0F80, 4'h0, RESP_OKAY,   0, 4};
        vt[20] = '{2, 1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, RESP_DECERR, 0, 0};

        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        for (int k = 0; k < 3; k++) begin
            araddr[k] = '0; awaddr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end

        #2 reset = 1'b0;
        #4;
        for (int k = 0; k < 3; k++) begin
            chk("reset_outputs",
                64'({arready[k], awready[k], wready[k], rvalid[k], bvalid[k],
                     rdata[k], rresp[k], bresp[k]}), 64'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk("ready_after_rst", 64'({arready[k], awready[k], wready[k]}),
                64'd7);
        end

        for (int i = 0; i < 21; i++) begin
            if (vt[i].wr)
                do_write(vt[i].k, vt[i].a, vt[i].d, vt[i].s, vt[i].r,
                         vt[i].order, vt[i].gap);
            else
                do_read(vt[i].k, vt[i].a, vt[i].d, vt[i].r, vt[i].gap);
        end

        // read sample and write commit land on the same edge
        do_write(0, 32'h8000_0030, 32'h0000_0001, 4'hF, RESP_OKAY, 0, 0);
        fork
            do_read(0, 32'h8000_0030, 32'h0000_0001, RESP_OKAY, 0);
            do_write(0, 32'h8000_0030, 32'h0000_0002, 4'hF, RESP_OKAY, 0, 0);
        join
        do_read(0, 32'h8000_0030, 32'h0000_0002, RESP_OKAY, 0);

        // reset while a write waits in W_WAIT
        do_write(0, 32'h8000_0020, 32'h1234_5678, 4'hF, RESP_OKAY, 0, 0);
        awaddr[0]  = 32'h8000_0020;
        wdata[0]   = 32'hFFFF_FFFF;
        wstrb[0]   = 4'hF;
        awvalid[0] = 1'b1;
        wvalid[0]  = 1'b1;
        @(negedge clock);
        awvalid[0] = 1'b0;
        wvalid[0]  = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_write",
            64'({arready[0], awready[0], wready[0], rvalid[0], bvalid[0],
                 rdata[0], rresp[0], bresp[0]}), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_rst2", 64'({arready[0], awready[0], wready[0]}),
            64'd7);
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (bvalid[0]) n++;
        end
        chk("no_b_after_rst", 64'(n), 64'd0);
        do_read(0, 32'h8000_0020, 32'h1234_5678, RESP_OKAY, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
